// File: rtl/ahb_arbiter_pkg.sv
// rtl/ahb_arbiter_pkg.sv - shared types and constants for the AHB round-robin arbiter
package ahb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_OWNED    = 2'd1,
    ST_HANDOVER = 2'd2
  } arb_state_e;

  localparam int AHB_SEL_W   = 4;
  localparam int AHB_BURST_W = 3;

  // Index width for n requesters; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ahb_arbiter_if.sv
// rtl/ahb_arbiter_if.sv - master-side request/bus bundle and shared slave-side bus
interface ahb_arbiter_if
  import ahb_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
);
  localparam int IDX_W = idx_width(NUM_MASTERS);

  logic [NUM_MASTERS-1:0]             hreq;
  logic [NUM_MASTERS*ADDR_W-1:0]      m_haddr;
  logic [NUM_MASTERS-1:0]             m_hwrite;
  logic [NUM_MASTERS*DATA_W-1:0]      m_hwdata;
  logic [NUM_MASTERS*AHB_SEL_W-1:0]   m_sel;
  logic [NUM_MASTERS-1:0]             m_hready;
  logic [NUM_MASTERS*AHB_BURST_W-1:0] m_hburst;

  logic [NUM_MASTERS-1:0]             hgrant;
  logic [IDX_W-1:0]                   hmaster;
  logic [ADDR_W-1:0]                  haddr;
  logic                               hwrite;
  logic [DATA_W-1:0]                  hwdata;
  logic [AHB_SEL_W-1:0]               sel;
  logic                               hready;
  logic [AHB_BURST_W-1:0]             hburst;
  logic                               bus_busy;
  logic                               hold_timeout;

  modport master (
    output hreq, m_haddr, m_hwrite, m_hwdata, m_sel, m_hready, m_hburst,
    input  hgrant, hmaster, haddr, hwrite, hwdata, sel, hready, hburst,
    input  bus_busy, hold_timeout
  );

  modport slave (
    input  hreq, m_haddr, m_hwrite, m_hwdata, m_sel, m_hready, m_hburst,
    output hgrant, hmaster, haddr, hwrite, hwdata, sel, hready, hburst,
    output bus_busy, hold_timeout
  );

endinterface

// File: rtl/ahb_arbiter_rr_picker.sv
// rtl/ahb_arbiter_rr_picker.sv - first set request at or above ptr, wrapping modulo N
module ahb_rr_picker
  import ahb_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = idx_width(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  int               j;
  logic [IDX_W-1:0] cand;

  // Walk offsets from farthest to nearest so the nearest hit is written last.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    j     = 0;
    cand  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      cand = IDX_W'(j);
      if (req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/ahb_arbiter.sv
// rtl/ahb_arbiter.sv - non-preemptive round-robin arbiter and shared-bus mux for up to 8 masters
module ahb_arbiter
  import ahb_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MAX_HOLD    = 16
) (
  input logic          hclk,
  input logic          hresetn,
  ahb_arbiter_if.slave bus
);

  localparam int IDX_W = idx_width(NUM_MASTERS);
  localparam int CNT_W = $clog2(MAX_HOLD + 1);

  arb_state_e             state_q, state_d;
  logic [NUM_MASTERS-1:0] hgrant_q, hgrant_d;
  logic [IDX_W-1:0]       hmaster_q, hmaster_d;
  logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   timeout_q, timeout_d;

  logic                   pick_valid;
  logic [IDX_W-1:0]       pick_idx;

  ahb_rr_picker #(
    .N     (NUM_MASTERS),
    .IDX_W (IDX_W)
  ) u_picker (
    .req   (bus.hreq),
    .ptr   (rr_ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q   <= ST_IDLE;
      hgrant_q  <= '0;
      hmaster_q <= '0;
      rr_ptr_q  <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hgrant_q  <= hgrant_d;
      hmaster_q <= hmaster_d;
      rr_ptr_q  <= rr_ptr_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    hgrant_d  = hgrant_q;
    hmaster_d = hmaster_q;
    rr_ptr_d  = rr_ptr_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    case (state_q)
      ST_OWNED: begin
        if (!bus.hreq[hmaster_q]) begin
          state_d  = ST_HANDOVER;
          hgrant_d = '0;
        end else begin
          if (cnt_q != CNT_W'(MAX_HOLD)) cnt_d = cnt_q + 1'b1;
          // Only a long hold that actually starves someone is flagged.
          if (cnt_d == CNT_W'(MAX_HOLD) && |(bus.hreq & ~hgrant_q)) timeout_d = 1'b1;
        end
      end
      default: begin
        if (pick_valid) begin
          state_d   = ST_OWNED;
          hgrant_d  = NUM_MASTERS'(1) << pick_idx;
          hmaster_d = pick_idx;
          rr_ptr_d  = (pick_idx == IDX_W'(NUM_MASTERS - 1)) ? '0 : pick_idx + 1'b1;
          cnt_d     = '0;
        end else begin
          state_d  = ST_IDLE;
          hgrant_d = '0;
        end
      end
    endcase
  end

  // Outside OWNED the bus is forced idle so a waiting master cannot leak onto it.
  always_comb begin
    bus.bus_busy = 1'b0;
    bus.haddr    = '0;
    bus.hwrite   = 1'b0;
    bus.hwdata   = '0;
    bus.sel      = '0;
    bus.hready   = 1'b0;
    bus.hburst   = '0;
    if (state_q == ST_OWNED) begin
      bus.bus_busy = 1'b1;
      bus.haddr    = bus.m_haddr[int'(hmaster_q)*ADDR_W +: ADDR_W];
      bus.hwrite   = bus.m_hwrite[hmaster_q];
      bus.hwdata   = bus.m_hwdata[int'(hmaster_q)*DATA_W +: DATA_W];
      bus.sel      = bus.m_sel[int'(hmaster_q)*AHB_SEL_W +: AHB_SEL_W];
      bus.hready   = bus.m_hready[hmaster_q];
      bus.hburst   = bus.m_hburst[int'(hmaster_q)*AHB_BURST_W +: AHB_BURST_W];
    end
  end

  assign bus.hgrant       = hgrant_q;
  assign bus.hmaster      = hmaster_q;
  assign bus.hold_timeout = timeout_q;

endmodule
